alu_accum_fsm: RTL and testbench

//  Parametrised registered ALU with an accumulator and a 4-state control FSM driven by in_sel.

---
 rtl/alu_accum_fsm.sv | 176 +++++++++++++++++
 tb/tb_alu_accum_fsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_fsm.sv
// Registered ALU with accumulator, flags, sticky overflow and op counter, steered by a 4-state FSM.
// Optional build macro ALU_SAT_EN: ADD/SUB clamp to the signed range on overflow instead of wrapping.
module alu_accum_fsm #(
    parameter int WIDTH   = 8,
    parameter int OPCNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         in_sel,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic [2:0]         op_sel,
    output logic [WIDTH-1:0]   out,
    output logic               carry,
    output logic               zero,
    output logic               ovf_sticky,
    output logic               result_valid,
    output logic [OPCNT_W-1:0] op_count,
    output logic [1:0]         curr_state,
    output logic [1:0]         next_state
);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'b00,
        S_LOAD    = 2'b01,
        S_PERSIST = 2'b10,
        S_HOLD    = 2'b11
    } state_e;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   SMAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   SMIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [OPCNT_W-1:0] CNT_ZERO = {OPCNT_W{1'b0}};
    localparam logic [OPCNT_W-1:0] CNT_ONE  = {{(OPCNT_W-1){1'b0}}, 1'b1};
    localparam logic [OPCNT_W-1:0] CNT_MAX  = {OPCNT_W{1'b1}};

    // Returns {carry, signed_ovf, result} for one operation.
    function automatic logic [WIDTH+1:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        ext = {(WIDTH+1){1'b0}};
        res = ZERO_W;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            3'b000: begin
                ext = {1'b0, a} + {1'b0, b};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                ext = {1'b0, a} - {1'b0, b};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: res = a & b;
            3'b011: res = a | b;
            3'b100: res = a ^ b;
            3'b101: res = ~a;
            3'b110: begin
                res = {a[WIDTH-2:0], 1'b0};
                c   = a[WIDTH-1];
            end
            3'b111: begin
                res = {1'b0, a[WIDTH-1:1]};
                c   = a[0];
            end
            default: res = ZERO_W;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of a for both ADD and SUB.
        if (v) begin
            res = a[WIDTH-1] ? SMIN_W : SMAX_W;
        end else begin
            res = res;
        end
`else
        v = v;
`endif
        return {c, v, res};
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [OPCNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_s;
    logic [WIDTH+1:0]   alu_s;

    // Next-state selection by in_sel priority: reset > load > persist > hold.
    always_comb begin
        state_d = S_HOLD;
        if (!rst_n) begin
            state_d = S_CLEAR;
        end else if (in_sel[0]) begin
            state_d = S_CLEAR;
        end else if (in_sel[1]) begin
            state_d = S_LOAD;
        end else if (in_sel[2]) begin
            state_d = S_PERSIST;
        end else begin
            state_d = S_HOLD;
        end
    end

    // Datapath next values, driven by the state being entered.
    always_comb begin
        opa_s   = (state_d == S_PERSIST) ? out_q : num1;
        alu_s   = alu_f(op_sel, opa_s, num2);
        out_d   = out_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_d)
            S_CLEAR: begin
                out_d   = ZERO_W;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                cnt_d   = CNT_ZERO;
            end
            S_LOAD, S_PERSIST: begin
                out_d   = alu_s[WIDTH-1:0];
                carry_d = alu_s[WIDTH+1];
                ovf_d   = (state_d == S_PERSIST) ? (ovf_q | alu_s[WIDTH]) : alu_s[WIDTH];
                valid_d = 1'b1;
                cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
            end
            S_HOLD: begin
                valid_d = 1'b0;
            end
            default: begin
                out_d = ZERO_W;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            out_q   <= ZERO_W;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out          = out_q;
    assign carry        = carry_q;
    assign zero         = (out_q == ZERO_W);
    assign ovf_sticky   = ovf_q;
    assign result_valid = valid_q;
    assign op_count     = cnt_q;
    assign curr_state   = state_q;
    assign next_state   = state_d;

endmodule

// File: tb/tb_alu_accum_fsm.sv
// Directed self-checking bench for alu_accum_fsm (WIDTH=8; op counter at 8 and 4 bits).
module tb_alu_accum_fsm;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [2:0] op_sel;

    logic [7:0] out_s, out4_s;
    logic       carry_s, carry4_s;
    logic       zero_s, zero4_s;
    logic       ovf_s, ovf4_s;
    logic       valid_s, valid4_s;
    logic [7:0] cnt_s;
    logic [3:0] cnt4_s;
    logic [1:0] cur_s, cur4_s;
    logic [1:0] nxt_s, nxt4_s;

    int n_checks;
    int n_errors;

    alu_accum_fsm #(.WIDTH(8), .OPCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_sel(in_sel), .num1(num1), .num2(num2),
        .op_sel(op_sel), .out(out_s), .carry(carry_s), .zero(zero_s),
        .ovf_sticky(ovf_s), .result_valid(valid_s), .op_count(cnt_s),
        .curr_state(cur_s), .next_state(nxt_s)
    );

    alu_accum_fsm #(.WIDTH(8), .OPCNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_sel(in_sel), .num1(num1), .num2(num2),
        .op_sel(op_sel), .out(out4_s), .carry(carry4_s), .zero(zero4_s),
        .ovf_sticky(ovf4_s), .result_valid(valid4_s), .op_count(cnt4_s),
        .curr_state(cur4_s), .next_state(nxt4_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        in_sel = sel;
        op_sel = op;
        num1   = a;
        num2   = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(3'b000, 3'b000, 8'h00, 8'h00);
        check_eq("rst_next_state", {30'd0, nxt_s}, 32'h0);
        step();
        step();
        check_eq("rst_out", {24'd0, out_s}, 32'h0);
        check_eq("rst_carry", {31'd0, carry_s}, 32'h0);
        check_eq("rst_zero", {31'd0, zero_s}, 32'h1);
        check_eq("rst_ovf", {31'd0, ovf_s}, 32'h0);
        check_eq("rst_valid", {31'd0, valid_s}, 32'h0);
        check_eq("rst_count", {24'd0, cnt_s}, 32'h0);
        check_eq("rst_state", {30'd0, cur_s}, 32'h0);

        rst_n = 1'b1;
        // 1: load ADD 57+1A
        drive(3'b010, 3'b000, 8'h57, 8'h1A);
        check_eq("t1_next_state", {30'd0, nxt_s}, 32'h1);
        step();
        check_eq("t1_out", {24'd0, out_s}, 32'h71);
        check_eq("t1_carry", {31'd0, carry_s}, 32'h0);
        check_eq("t1_valid", {31'd0, valid_s}, 32'h1);
        check_eq("t1_state", {30'd0, cur_s}, 32'h1);
        check_eq("t1_count", {24'd0, cnt_s}, 32'h1);
        check_eq("t1_zero", {31'd0, zero_s}, 32'h0);

        // 2: persist SUB 1A, then hold
        drive(3'b100, 3'b001, 8'h00, 8'h1A);
        step();
        check_eq("t2_out", {24'd0, out_s}, 32'h57);
        check_eq("t2_state", {30'd0, cur_s}, 32'h2);
        check_eq("t2_count", {24'd0, cnt_s}, 32'h2);
        drive(3'b000, 3'b000, 8'h00, 8'h00);
        check_eq("t2_next_hold", {30'd0, nxt_s}, 32'h3);
        step();
        check_eq("t2_hold_out", {24'd0, out_s}, 32'h57);
        check_eq("t2_hold_valid", {31'd0, valid_s}, 32'h0);
        check_eq("t2_hold_state", {30'd0, cur_s}, 32'h3);
        check_eq("t2_hold_count", {24'd0, cnt_s}, 32'h2);

        // 3: signed overflow, sticky, then cleared by a fresh load
        drive(3'b010, 3'b000, 8'h7F, 8'h01);
        step();
`ifdef ALU_SAT_EN
        check_eq("t3_ovf_out", {24'd0, out_s}, 32'h7F);
`else
        check_eq("t3_ovf_out", {24'd0, out_s}, 32'h80);
`endif
        check_eq("t3_ovf", {31'd0, ovf_s}, 32'h1);
        check_eq("t3_carry", {31'd0, carry_s}, 32'h0);
        drive(3'b100, 3'b010, 8'h00, 8'hFF);
        step();
`ifdef ALU_SAT_EN
        check_eq("t3_and_out", {24'd0, out_s}, 32'h7F);
`else
        check_eq("t3_and_out", {24'd0, out_s}, 32'h80);
`endif
        check_eq("t3_ovf_sticky", {31'd0, ovf_s}, 32'h1);
        drive(3'b010, 3'b000, 8'h01, 8'h01);
        step();
        check_eq("t3_reload_out", {24'd0, out_s}, 32'h02);
        check_eq("t3_reload_ovf", {31'd0, ovf_s}, 32'h0);

        // SUB borrow and SUB signed overflow
        drive(3'b010, 3'b001, 8'h05, 8'h07);
        step();
        check_eq("sub_borrow_out", {24'd0, out_s}, 32'hFE);
        check_eq("sub_borrow_c", {31'd0, carry_s}, 32'h1);
        check_eq("sub_borrow_ovf", {31'd0, ovf_s}, 32'h0);
        drive(3'b010, 3'b001, 8'h80, 8'h01);
        step();
`ifdef ALU_SAT_EN
        check_eq("sub_ovf_out", {24'd0, out_s}, 32'h80);
`else
        check_eq("sub_ovf_out", {24'd0, out_s}, 32'h7F);
`endif
        check_eq("sub_ovf_c", {31'd0, carry_s}, 32'h0);
        check_eq("sub_ovf", {31'd0, ovf_s}, 32'h1);

        // ADD unsigned carry without signed overflow
        drive(3'b010, 3'b000, 8'hFF, 8'h02);
        step();
        check_eq("add_carry_out", {24'd0, out_s}, 32'h01);
        check_eq("add_carry_c", {31'd0, carry_s}, 32'h1);
        check_eq("add_carry_ovf", {31'd0, ovf_s}, 32'h0);

        // logic ops chain: OR, XOR, NOT
        drive(3'b010, 3'b011, 8'hF0, 8'h0F);
        step();
        check_eq("or_out", {24'd0, out_s}, 32'hFF);
        check_eq("or_carry", {31'd0, carry_s}, 32'h0);
        drive(3'b100, 3'b100, 8'h00, 8'hFF);
        step();
        check_eq("xor_out", {24'd0, out_s}, 32'h00);
        check_eq("xor_zero", {31'd0, zero_s}, 32'h1);
        drive(3'b100, 3'b101, 8'h00, 8'h00);
        step();
        check_eq("not_out", {24'd0, out_s}, 32'hFF);

        // 4: shifts
        drive(3'b010, 3'b110, 8'h81, 8'h00);
        step();
        check_eq("shl_out", {24'd0, out_s}, 32'h02);
        check_eq("shl_carry", {31'd0, carry_s}, 32'h1);
        drive(3'b100, 3'b111, 8'h00, 8'h00);
        step();
        check_eq("shr_out", {24'd0, out_s}, 32'h01);
        check_eq("shr_carry", {31'd0, carry_s}, 32'h0);

        // priority: load beats persist
        drive(3'b110, 3'b010, 8'h3C, 8'h0F);
        check_eq("prio_next_load", {30'd0, nxt_s}, 32'h1);
        step();
        check_eq("prio_load_out", {24'd0, out_s}, 32'h0C);

        // 5: all in_sel bits set mid-chain after an overflow
        drive(3'b010, 3'b000, 8'h7F, 8'h01);
        step();
        check_eq("t5_pre_ovf", {31'd0, ovf_s}, 32'h1);
        drive(3'b111, 3'b000, 8'h12, 8'h34);
        check_eq("t5_next_state", {30'd0, nxt_s}, 32'h0);
        step();
        check_eq("t5_out", {24'd0, out_s}, 32'h0);
        check_eq("t5_zero", {31'd0, zero_s}, 32'h1);
        check_eq("t5_count", {24'd0, cnt_s}, 32'h0);
        check_eq("t5_state", {30'd0, cur_s}, 32'h0);
        check_eq("t5_ovf", {31'd0, ovf_s}, 32'h0);
        check_eq("t5_valid", {31'd0, valid_s}, 32'h0);

        // 6: 20 persisted ADD 1 from a clear accumulator
        drive(3'b100, 3'b000, 8'h00, 8'h01);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check_eq("t6_out", {24'd0, out_s}, 32'h14);
        check_eq("t6_count8", {24'd0, cnt_s}, 32'h14);
        check_eq("t6_count4_sat", {28'd0, cnt4_s}, 32'hF);
        check_eq("t6_out4", {24'd0, out4_s}, 32'h14);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_next", {30'd0, nxt4_s}, 32'h0);
        step();
        check_eq("t6_rst_out4", {24'd0, out4_s}, 32'h0);
        check_eq("t6_rst_count4", {28'd0, cnt4_s}, 32'h0);
        check_eq("t6_rst_zero4", {31'd0, zero4_s}, 32'h1);
        check_eq("t6_rst_state4", {30'd0, cur4_s}, 32'h0);
        check_eq("t6_rst_valid4", {31'd0, valid4_s}, 32'h0);
        check_eq("t6_rst_carry4", {31'd0, carry4_s}, 32'h0);
        check_eq("t6_rst_ovf4", {31'd0, ovf4_s}, 32'h0);
        check_eq("t6_rst_count8", {24'd0, cnt_s}, 32'h0);
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
